// File: rtl/calc_pkg.sv
// Shared constants for the signed calculator's key-input path.
package calc_pkg;
  localparam int KEY_W  = 8;
  localparam int CODE_W = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;
endpackage

// File: rtl/priority_encoder_8_3.sv
// Combinational 8-to-3 priority encoder, bit 7 highest; also flags any/multiple set bits.
module priority_encoder_8_3
  import calc_pkg::*;
(
  input  logic [KEY_W-1:0]  in,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              multi
);
  logic [KEY_W-1:0] seen;

  assign idx[2] = in[7] | in[6] | in[5] | in[4];
  assign idx[1] = in[7] | in[6] | (~in[5] & ~in[4] & (in[3] | in[2]));
  assign idx[0] = in[7] | (~in[6] & in[5]) | (~in[6] & ~in[4] & in[3])
                | (~in[6] & ~in[4] & ~in[2] & in[1]);
  assign any    = |in;

  // seen[i] is set when any lower-order bit is set; a set bit with seen set means popcount > 1
  always_comb begin
    seen[0] = 1'b0;
    for (int i = 1; i < KEY_W; i++) begin
      seen[i] = seen[i-1] | in[i-1];
    end
  end

  assign multi = |(in & seen);
endmodule

// File: rtl/op_key_encoder_8_3.sv
// Registered 8-to-3 priority encoder for the operation keys with valid/ready handshake.
// Optional input debounce is built when OP_KEY_DEBOUNCE_EN is defined.
module op_key_encoder_8_3
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  req,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              multi
);
  logic [1:0]        state;
  logic [KEY_W-1:0]  snap;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;
  logic              enc_multi;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be in 1..15");
  end

  priority_encoder_8_3 u_enc (
    .in    (snap),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

`ifdef OP_KEY_DEBOUNCE_EN
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES);
  logic [3:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      snap  <= '0;
      code  <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
`ifdef OP_KEY_DEBOUNCE_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != '0) begin
            snap <= req;
`ifdef OP_KEY_DEBOUNCE_EN
            cnt  <= 4'd1;
            // a single-cycle debounce window is satisfied by the first sample
            state <= (DEBOUNCE_CYCLES <= 1) ? ST_HOLD : ST_DEBOUNCE;
`else
            state <= ST_HOLD;
`endif
          end
        end
`ifdef OP_KEY_DEBOUNCE_EN
        ST_DEBOUNCE: begin
          if (req == '0) begin
            state <= ST_IDLE;
          end else if (req == snap) begin
            cnt <= cnt + 4'd1;
            if ((cnt + 4'd1) >= DB_LAST) state <= ST_HOLD;
          end else begin
            snap <= req;
            cnt  <= 4'd1;
          end
        end
`endif
        ST_HOLD: begin
          // first HOLD cycle loads the outputs; the handshake only counts once valid is up
          if (!valid) begin
            valid <= enc_any;
            code  <= enc_idx;
            multi <= enc_multi;
          end else if (ready) begin
            valid <= 1'b0;
            state <= (req == '0) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (req == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_op_key_encoder_8_3.sv
// Self-checking bench for op_key_encoder_8_3 (default build, debounce disabled).
module tb_op_key_encoder_8_3;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic       multi;

  int checks = 0;
  int failures = 0;

  op_key_encoder_8_3 dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ready (ready),
    .code  (code),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  // Reference: event-level view of the key encoder
  logic       m_valid, m_pending, m_need_rel, m_multi;
  logic [2:0] m_code;
  logic [7:0] m_snap;

  function automatic logic [2:0] top_bit(input logic [7:0] v);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_pending <= 1'b0; m_need_rel <= 1'b0;
      m_code <= 3'd0; m_multi <= 1'b0; m_snap <= 8'h00;
    end else if (m_valid) begin
      if (ready) begin
        m_valid    <= 1'b0;
        m_need_rel <= (req != 8'h00);
      end
    end else if (m_pending) begin
      m_pending <= 1'b0;
      m_valid   <= 1'b1;
      m_code    <= top_bit(m_snap);
      m_multi   <= ($countones(m_snap) > 1);
    end else if (m_need_rel) begin
      if (req == 8'h00) m_need_rel <= 1'b0;
    end else if (req != 8'h00) begin
      m_snap    <= req;
      m_pending <= 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the reference on every falling edge
  always @(negedge clk) begin
    if (rst) begin
      chk("model_valid", int'(valid), int'(m_valid));
      if (m_valid) begin
        chk("model_code", int'(code), int'(m_code));
        chk("model_multi", int'(multi), int'(m_multi));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with all keys pressed
    rst = 1'b0; req = 8'hFF; ready = 1'b0;
    repeat (3) tick();
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_multi", int'(multi), 0);
    req = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_valid", int'(valid), 0);

    // Single one-cycle press
    req = 8'b0000_1000; tick();
    req = 8'h00;        tick();
    chk("single_valid", int'(valid), 1);
    chk("single_code", int'(code), 3);
    chk("single_multi", int'(multi), 0);
    repeat (10) tick();
    chk("single_held", int'(valid), 1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("single_done", int'(valid), 0);
    tick();

    // Multi-hot held key, handshake while held
    req = 8'b1000_0001; tick(); tick();
    chk("multi_valid", int'(valid), 1);
    chk("multi_code", int'(code), 7);
    chk("multi_multi", int'(multi), 1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("multi_done", int'(valid), 0);
    repeat (5) tick();
    chk("release_hold", int'(valid), 0);
    req = 8'h00; tick();
    req = 8'h02; tick();
    req = 8'h00; tick();
    chk("rearm_valid", int'(valid), 1);
    chk("rearm_code", int'(code), 1);
    ready = 1'b1; tick(); ready = 1'b0;

    // Async reset while an event is held
    req = 8'h10; tick();
    req = 8'h00; tick();
    chk("pre_rst_valid", int'(valid), 1);
    @(negedge clk); #1;
    rst = 1'b0; #1;
    chk("async_rst_valid", int'(valid), 0);
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", int'(valid), 0);
    req = 8'h04; tick();
    req = 8'h00; tick();
    chk("fresh_valid", int'(valid), 1);
    chk("fresh_code", int'(code), 2);
    ready = 1'b1; tick(); ready = 1'b0;

    // Ready held high while idle
    ready = 1'b1;
    repeat (3) tick();
    chk("idle_ready_valid", int'(valid), 0);
    req = 8'h40; tick();
    req = 8'h00; tick();
    chk("pulse_valid", int'(valid), 1);
    chk("pulse_code", int'(code), 6);
    tick();
    chk("pulse_gone", int'(valid), 0);
    ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    req = 8'h00; ready = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
